// File: rtl/pipe_reg_chain.sv
// Parametrised valid/ready register chain: zero-extends IN_WIDTH-bit input to
// WIDTH bits and carries it through DEPTH stages with backpressure and flush.
module pipe_reg_chain #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned IN_WIDTH = 4,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [CNT_W-1:0]    occupancy
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] mv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [CNT_W-1:0] occ_nxt;
  logic             free_down;

  // Move ripple from the output side back to the input.
  always_comb begin
    mv        = '0;
    free_down = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      mv[k]     = vld[k] & free_down;
      free_down = ~vld[k] | mv[k];
    end
  end

  assign in_ready = ~vld[0] | mv[0];

  // Stage loads and next valids; flush cancels every transfer into a stage.
  always_comb begin
    load    = '0;
    vld_nxt = '0;
    occ_nxt = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (k == 0) begin
        load[k] = in_valid & in_ready & ~flush;
      end else begin
        load[k] = mv[k-1] & ~flush;
      end
      if (flush) begin
        vld_nxt[k] = 1'b0;
      end else if (load[k]) begin
        vld_nxt[k] = 1'b1;
      end else begin
        vld_nxt[k] = vld[k] & ~mv[k];
      end
      occ_nxt = occ_nxt + CNT_W'(vld_nxt[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld       <= '0;
      occupancy <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        dat[k] <= '0;
      end
    end else begin
      vld       <= vld_nxt;
      occupancy <= occ_nxt;
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (load[k]) begin
          if (k == 0) begin
            dat[k] <= WIDTH'(in_data);
          end else begin
            dat[k] <= dat[k-1];
          end
        end
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (WIDTH=8, IN_WIDTH=4, DEPTH=3).
module tb_pipe_reg_chain;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] occupancy;

  int total = 0;
  int bad   = 0;

  pipe_reg_chain #(.WIDTH(8), .IN_WIDTH(4), .DEPTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int         exp_occ [4] = '{1, 1, 1, 0};
    logic       exp_vld [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'hA;
    tick();
    in_valid = 1'b0; in_data = 4'h0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (occupancy !== 2'(exp_occ[i])) begin
        bad++; $display("FAIL latency_occ[%0d] got=%0d exp=%0d", i, occupancy, exp_occ[i]);
      end
      total++;
      if (out_valid !== exp_vld[i]) begin
        bad++; $display("FAIL latency_valid[%0d] got=%b exp=%b", i, out_valid, exp_vld[i]);
      end
      if (exp_vld[i]) begin
        total++;
        if (out_data !== 8'h0A) begin bad++; $display("FAIL latency_data got=%h exp=0a", out_data); end
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int e = 0; e < 13; e++) begin
      if (e < 10) begin
        in_valid = 1'b1; in_data = 4'(e + 1);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", e, in_ready); end
      end else begin
        in_valid = 1'b0; in_data = 4'h0;
      end
      tick();
      total++;
      if (out_valid !== (e >= 2 && e <= 11)) begin
        bad++; $display("FAIL stream_valid[%0d] got=%b exp=%b", e, out_valid, (e >= 2 && e <= 11));
      end
      if (e >= 2 && e <= 11) begin
        total++;
        if (out_data !== 8'(e - 1)) begin
          bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", e, out_data, 8'(e - 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 4'(i + 1);
      #1;
      total++;
      if (in_ready !== (i < 3)) begin
        bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=%b", i, in_ready, (i < 3));
      end
      if (i < 4) tick();
    end
    total++; if (occupancy !== 2'd3) begin bad++; $display("FAIL bp_occ got=%0d exp=3", occupancy); end
    // Producer keeps offering beat 4, which was never accepted.
    in_data = 4'h4;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'(i + 1)) begin
        bad++; $display("FAIL bp_drain[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, 8'(i + 1));
      end
      tick();
      in_valid = 1'b0;
    end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL bp_drained_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h5;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_data = 4'h7;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL bubble_occ got=%0d exp=2", occupancy); end
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h05) begin
      bad++; $display("FAIL bubble_head got=%b/%h exp=1/05", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h07) begin
      bad++; $display("FAIL bubble_adjacent got=%b/%h exp=1/07", out_valid, out_data);
    end
    tick();
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL bubble_empty_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'(8 + i);
      tick();
    end
    total++; if (occupancy !== 2'd3) begin bad++; $display("FAIL flush_full_occ got=%0d exp=3", occupancy); end
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 4'hF;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_emit[%0d] got=%b exp=0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'(3 + i);
      tick();
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h03 || occupancy !== 2'd3) begin
      bad++; $display("FAIL arst_pre got=%b/%h/%0d exp=1/03/3", out_valid, out_data, occupancy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL arst_data got=%h exp=00", out_data); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL arst_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      bad++; $display("FAIL arst_after got=%b/%0d exp=0/0", out_valid, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
- Parametrised, multi-stage valid/ready register chain.
- Input data of IN_WIDTH bits is zero-extended to WIDTH bits and carried through DEPTH register stages.
- Successor to the fixed 2-bit, single-stage capture register: adds configurable width and depth, a flow-control handshake, flush, and an occupancy count.
- Sits between producer and consumer datapaths wherever retiming with backpressure is required.

Parameters:
- WIDTH, 8, stored/output data width in bits; must be >= 1.
- IN_WIDTH, 4, input data width in bits; 1 <= IN_WIDTH <= WIDTH; MSBs are zero-filled on entry.
- DEPTH, 3, number of register stages; must be >= 1.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low, deasserted synchronously by the system.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  producer has data.
- in_ready  output  1  chain accepts data this cycle.
- in_data  input  IN_WIDTH  producer data.
- out_valid  output  1  last stage holds data.
- out_ready  input  1  consumer takes data.
- out_data  output  WIDTH  last-stage data.
- occupancy  output  CNT_W  number of valid stages.

Behaviour:
- State per stage k (0 = input side, DEPTH-1 = output): vld[k] (1 bit) and dat[k] (WIDTH bits).
- Reset (rst_n = 0, asynchronous):
  - all vld[k] = 0 and all dat[k] = 0;
  - out_valid = 0, out_data = 0, occupancy = 0.
  - in_ready follows its combinational definition, so it reads 1 during reset unless out_ready is low with... (no: every stage is empty, so in_ready = 1 during reset).
- Move condition, computed combinationally from the output side back to the input:
  - mv[DEPTH-1] = vld[DEPTH-1] & out_ready.
  - mv[k] = vld[k] & (~vld[k+1] | mv[k+1]) for k < DEPTH-1.
  - Stage k is free this cycle when ~vld[k] | mv[k].
- in_ready = ~vld[0] | mv[0].
  - Purely combinational from out_ready and vld[]; there is no combinational path from in_valid to in_ready.
- Clock-edge update, without flush:
  - Stage k+1 loads dat[k] when mv[k] = 1.
  - Stage 0 loads {zeros, in_data} when in_valid & in_ready.
  - vld[k] is next 1 if the stage was loaded, otherwise vld[k] & ~mv[k].
  - dat[k] holds its value when not loaded, including when it goes invalid; no clearing is required.
- Zero extension:
  - dat[0][IN_WIDTH-1:0] = in_data.
  - dat[0][WIDTH-1:IN_WIDTH] = 0.
  - When IN_WIDTH = WIDTH there is no zero-fill.
- Latency and throughput:
  - Data accepted at edge n is presented on out_data/out_valid after edge n+DEPTH-1, i.e. DEPTH cycles from the accepting cycle, provided the chain is unstalled.
  - Full throughput of one beat per cycle when out_ready stays high.
  - Bubbles collapse: an empty stage is filled even while downstream stages are stalled.
- Stall:
  - out_ready = 0 with out_valid = 1: out_data and out_valid hold stable until the transfer.
  - Upstream stages keep filling until all DEPTH stages are valid; in_ready then drops to 0.
- Full chain with out_ready = 1: in_ready = 1 in the same cycle (pass-through ripple), so the chain accepts and emits simultaneously.
- flush = 1 at an edge:
  - all vld[k] are cleared and dat[] is unchanged;
  - the input beat offered in that cycle is discarded, even if in_valid & in_ready;
  - the output beat counts as consumed by the consumer if out_ready = 1, but no other transfer takes effect.
  - flush does not affect in_ready combinationally.
- occupancy: registered population count of vld[], updated at the same edge as vld[]; it ranges 0..DEPTH.
- Reset asserted mid-transfer: all in-flight data is lost immediately (asynchronous); the chain is empty on deassertion.
- No X on any output after reset, regardless of input X's while in_valid = 0.

Test Plan:
- Basic latency: WIDTH=8, IN_WIDTH=4, DEPTH=3, out_ready=1; in_data=4'hA with in_valid pulsed at cycle 0 -> out_valid=1 and out_data=8'h0A at cycle 3, for exactly one cycle; occupancy sequence 1,1,1,0.
- Streaming: in_valid=1 with in_data = 1..10 on consecutive cycles, out_ready=1 -> out_data = 8'h01..8'h0A on consecutive cycles starting at cycle 3; in_ready constant 1.
- Backpressure: out_ready=0 with 5 beats offered -> 3 beats accepted, in_ready=0 from the 4th cycle, occupancy=3; out_ready=1 -> beats emerge in order with no loss or duplication, and in_ready=1 in the same cycle.
- Bubble collapse: load beat A, then stall out_ready=0 with a 2-cycle gap before beat B -> B advances until it is adjacent to A; occupancy=2.
- Flush: chain full (occupancy=3), flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, offered beat not emitted later.
- Async reset: assert rst_n=0 mid-stream between clock edges -> out_valid, out_data and occupancy go to 0 immediately without a clock edge; in_ready=1.
